// File: rtl/segment_packer.sv
// Packs host pipe words into 128-bit clock-segment records, validates them and
// hands them to the segment FIFO through a single-entry output buffer.
module segment_packer #(
  parameter int unsigned WORDS_PER_SEG = 8,
  parameter int unsigned SEG_WIDTH     = WORDS_PER_SEG * 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 ti_clk,
  input  logic                 reset,
  input  logic                 pipe_write,
  input  logic [15:0]          pipe_data,
  input  logic                 flush,
  input  logic                 fifo_full,
  output logic [SEG_WIDTH-1:0] fifo_din,
  output logic                 fifo_wr_en,
  output logic [CNT_WIDTH-1:0] seg_count,
  output logic [CNT_WIDTH-1:0] bad_count,
  output logic [15:0]          status
);

  localparam int unsigned IdxW  = (WORDS_PER_SEG > 1) ? $clog2(WORDS_PER_SEG) : 1;
  localparam int unsigned RepW  = 32;
  localparam int unsigned OnLsb = RepW + 48;

  logic [IdxW-1:0]      word_idx_q, word_idx_d;
  logic [SEG_WIDTH-1:0] asm_q, asm_d;
  logic [SEG_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] seg_count_q, seg_count_d;
  logic [CNT_WIDTH-1:0] bad_count_q, bad_count_d;
  logic                 ovf_q, ovf_d;
  logic                 bad_seen_q, bad_seen_d;

  logic                 accept;
  logic                 seg_done;
  logic [SEG_WIDTH-1:0] record;
  logic [RepW-1:0]      rep_cnt;
  logic [OnLsb-RepW-1:0] off_cnt;
  logic [SEG_WIDTH-OnLsb-1:0] on_cnt;
  logic                 rec_ok;
  logic                 drain;
  logic                 rec_load;
  logic                 rec_ovf;
  logic                 rec_bad;

  assign accept   = pipe_write & ~flush;
  assign seg_done = accept && (word_idx_q == IdxW'(WORDS_PER_SEG - 1));

  // Assembly register with the current word merged in, so word 7 is part of the check.
  always_comb begin
    record = asm_q;
    for (int k = 0; k < int'(WORDS_PER_SEG); k++) begin
      if (word_idx_q == IdxW'(k)) begin
        record[16*k +: 16] = pipe_data;
      end
    end
  end

  assign rep_cnt = record[RepW-1:0];
  assign off_cnt = record[OnLsb-1:RepW];
  assign on_cnt  = record[SEG_WIDTH-1:OnLsb];

  // Retrigger records (repeat==0) use on_counts as a timeout and ignore off_counts.
  assign rec_ok = (rep_cnt == '0) || ((on_cnt != '0) && (off_cnt != '0));

  assign drain    = out_valid_q & ~fifo_full;
  assign rec_load = seg_done & rec_ok & (~out_valid_q | drain);
  assign rec_ovf  = seg_done & rec_ok & out_valid_q & fifo_full;
  assign rec_bad  = seg_done & ~rec_ok;

  always_comb begin
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    seg_count_d = seg_count_q;
    bad_count_d = bad_count_q;
    ovf_d       = ovf_q;
    bad_seen_d  = bad_seen_q;

    if (flush) begin
      word_idx_d  = '0;
      asm_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      seg_count_d = '0;
      bad_count_d = '0;
      ovf_d       = 1'b0;
      bad_seen_d  = 1'b0;
    end else begin
      if (accept) begin
        if (seg_done) begin
          word_idx_d = '0;
          asm_d      = '0;
        end else begin
          word_idx_d = word_idx_q + IdxW'(1);
          asm_d      = record;
        end
      end

      if (drain) begin
        out_valid_d = 1'b0;
        seg_count_d = seg_count_q + CNT_WIDTH'(1);
      end

      // A load on the drain edge keeps out_valid high with the new record.
      if (rec_load) begin
        out_data_d  = record;
        out_valid_d = 1'b1;
      end

      if (rec_ovf) begin
        ovf_d = 1'b1;
      end

      if (rec_bad) begin
        bad_count_d = bad_count_q + CNT_WIDTH'(1);
        bad_seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      word_idx_q  <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      seg_count_q <= '0;
      bad_count_q <= '0;
      ovf_q       <= 1'b0;
      bad_seen_q  <= 1'b0;
    end else begin
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      seg_count_q <= seg_count_d;
      bad_count_q <= bad_count_d;
      ovf_q       <= ovf_d;
      bad_seen_q  <= bad_seen_d;
    end
  end

  assign fifo_wr_en = drain;
  assign fifo_din   = out_data_q;
  assign seg_count  = seg_count_q;
  assign bad_count  = bad_count_q;
  assign status     = {12'h000, out_valid_q, (word_idx_q != '0), bad_seen_q, ovf_q};

endmodule

// File: tb/tb_segment_packer.sv
// Directed bench for segment_packer: FIFO writes are captured by a monitor and
// compared with hand-computed records.
module tb_segment_packer;

  logic         ti_clk;
  logic         reset;
  logic         pipe_write;
  logic [15:0]  pipe_data;
  logic         flush;
  logic         fifo_full;
  logic [127:0] fifo_din;
  logic         fifo_wr_en;
  logic [15:0]  seg_count;
  logic [15:0]  bad_count;
  logic [15:0]  status;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [127:0] wr_q[$];

  // Words listed most-significant first; word 0 is the rightmost group.
  localparam logic [127:0] SegA = 128'h0002_0000_0003_0000_0000_0005_0000_0001;
  localparam logic [127:0] SegB = 128'h0000_0000_0000_0000_0000_000a_0000_0003;
  localparam logic [127:0] SegC = 128'h0000_0000_0009_0000_0000_0004_0000_0007;
  localparam logic [127:0] SegD = 128'h0001_0000_0008_0000_0000_0006_0000_0002;

  segment_packer dut (
    .ti_clk     (ti_clk),
    .reset      (reset),
    .pipe_write (pipe_write),
    .pipe_data  (pipe_data),
    .flush      (flush),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .seg_count  (seg_count),
    .bad_count  (bad_count),
    .status     (status)
  );

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  always @(posedge ti_clk) begin
    if (!reset && fifo_wr_en) wr_q.push_back(fifo_din);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pipe_write = 1'b0;
    pipe_data  = '0;
    flush      = 1'b0;
    fifo_full  = 1'b0;
    tick(2);
    reset = 1'b0;
    wr_q.delete();
  endtask

  task automatic send_words(input logic [127:0] seg, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      pipe_write = 1'b1;
      pipe_data  = seg[16*k +: 16];
      tick(1);
    end
    pipe_write = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset state
    do_reset();
    check_eq("rst_wr_en", 128'(fifo_wr_en), 128'd0);
    check_eq("rst_din", fifo_din, 128'd0);
    check_eq("rst_seg", 128'(seg_count), 128'd0);
    check_eq("rst_bad", 128'(bad_count), 128'd0);
    check_eq("rst_status", 128'(status), 128'd0);

    // Valid segment, write the cycle after word 7
    send_words(SegA, 0, 6);
    check_eq("a_partial", 128'(status), 128'h0004);
    check_eq("a_no_early_wr", 128'(fifo_wr_en), 128'd0);
    send_words(SegA, 7, 7);
    check_eq("a_wr_en", 128'(fifo_wr_en), 128'd1);
    check_eq("a_din", fifo_din, SegA);
    check_eq("a_pending", 128'(status), 128'h0008);
    tick(1);
    check_eq("a_wr_done", 128'(fifo_wr_en), 128'd0);
    check_eq("a_seg", 128'(seg_count), 128'd1);
    check_eq("a_status", 128'(status), 128'd0);
    check_eq("a_nwr", 128'(wr_q.size()), 128'd1);
    if (wr_q.size() > 0) check_eq("a_wr_data", wr_q[0], SegA);

    // Invalid drop then valid segment
    do_reset();
    send_words(SegB, 0, 7);
    check_eq("b_no_wr", 128'(fifo_wr_en), 128'd0);
    check_eq("b_bad", 128'(bad_count), 128'd1);
    check_eq("b_status", 128'(status), 128'h0002);
    send_words(SegD, 0, 7);
    tick(2);
    check_eq("b_seg", 128'(seg_count), 128'd1);
    check_eq("b_nwr", 128'(wr_q.size()), 128'd1);
    if (wr_q.size() > 0) check_eq("b_wr_data", wr_q[0], SegD);
    check_eq("b_status_sticky", 128'(status), 128'h0002);

    // Back-pressure held for 20 cycles
    do_reset();
    fifo_full = 1'b1;
    send_words(SegC, 0, 7);
    tick(20);
    check_eq("bp_no_wr", 128'(wr_q.size()), 128'd0);
    check_eq("bp_wr_en", 128'(fifo_wr_en), 128'd0);
    check_eq("bp_status", 128'(status), 128'h0008);
    fifo_full = 1'b0;
    #1;
    check_eq("bp_release_wr_en", 128'(fifo_wr_en), 128'd1);
    tick(3);
    check_eq("bp_nwr", 128'(wr_q.size()), 128'd1);
    if (wr_q.size() > 0) check_eq("bp_wr_data", wr_q[0], SegC);
    check_eq("bp_status_after", 128'(status), 128'd0);
    check_eq("bp_seg", 128'(seg_count), 128'd1);

    // Overflow: second record dropped while the first is held
    do_reset();
    fifo_full = 1'b1;
    send_words(SegA, 0, 7);
    send_words(SegC, 0, 7);
    check_eq("ovf_status", 128'(status), 128'h0009);
    check_eq("ovf_held", fifo_din, SegA);
    check_eq("ovf_seg_held", 128'(seg_count), 128'd0);
    fifo_full = 1'b0;
    tick(4);
    check_eq("ovf_nwr", 128'(wr_q.size()), 128'd1);
    if (wr_q.size() > 0) check_eq("ovf_wr_data", wr_q[0], SegA);
    check_eq("ovf_seg", 128'(seg_count), 128'd1);
    check_eq("ovf_status_after", 128'(status), 128'h0001);

    // Drain and load on the same edge
    do_reset();
    fifo_full = 1'b1;
    send_words(SegA, 0, 7);
    send_words(SegC, 0, 6);
    pipe_write = 1'b1;
    pipe_data  = SegC[127:112];
    fifo_full  = 1'b0;
    tick(1);
    pipe_write = 1'b0;
    check_eq("sim_wr_en", 128'(fifo_wr_en), 128'd1);
    check_eq("sim_din", fifo_din, SegC);
    tick(3);
    check_eq("sim_nwr", 128'(wr_q.size()), 128'd2);
    if (wr_q.size() > 1) begin
      check_eq("sim_wr0", wr_q[0], SegA);
      check_eq("sim_wr1", wr_q[1], SegC);
    end
    check_eq("sim_seg", 128'(seg_count), 128'd2);
    check_eq("sim_status", 128'(status), 128'd0);

    // Flush mid-segment, colliding with a pipe write
    do_reset();
    send_words(SegB, 0, 7);
    send_words(SegA, 0, 2);
    pipe_write = 1'b1;
    pipe_data  = 16'hffff;
    flush      = 1'b1;
    tick(1);
    pipe_write = 1'b0;
    flush      = 1'b0;
    check_eq("fl_status", 128'(status), 128'd0);
    check_eq("fl_bad", 128'(bad_count), 128'd0);
    check_eq("fl_seg", 128'(seg_count), 128'd0);
    send_words(SegD, 0, 7);
    check_eq("fl_din", fifo_din, SegD);
    tick(2);
    check_eq("fl_nwr", 128'(wr_q.size()), 128'd1);
    check_eq("fl_seg_after", 128'(seg_count), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
